dma_seq_2940: RTL

//  Upstream control stage for implementare2940 (the Am2940 DMA address generator).
//  It accepts a block-transfer request (start address, word count, mode) and programs
//  the 2940 through its instr/DataIn bus: write CR, load address, load word count.
//  It then gates counting through aci/wci, one step per accepted device word, and

---
 rtl/dma_seq_2940.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dma_seq_2940.sv
`default_nettype none
// ============================================================================
// Module      : dma_seq_2940
// Description : Control stage in front of an Am2940 DMA address generator.
//               Takes a block-transfer request, programs the 2940 over its
//               instr/DataIn bus (control register, address, word count),
//               then gates the 2940 counters one step per accepted device
//               word until the 2940 reports end of count on wco.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1    system clock, rising edge
//   rst       in   1    synchronous active-high reset
//   start     in   1    begin transfer (only looked at while idle)
//   src_addr  in   AW   start address for the 2940 address counter
//   word_cnt  in   AW   number of words to transfer (0 = finish at once)
//   mode      in   3    2940 control register value
//   xfer_req  in   1    device has a word ready this cycle
//   repeat_en in   1    (AUTOREINIT_EN only) restart the block after DONE
//   xfer_ack  out  1    word accepted this cycle
//   wco       in   1    2940 word-count carry out, active low = complete
//   instr     out  CW   2940 instruction
//   DataIn    out  AW   2940 data bus
//   aci       out  1    address-counter carry in, active low
//   wci       out  1    word-counter carry in, active low
//   busy      out  1    transfer in progress (through the DONE cycle)
//   done      out  1    one-cycle completion pulse
//   xfer_cnt  out  AW   words accepted in the current/last transfer
// Build option
//   AUTOREINIT_EN : adds repeat_en and a REINIT state that re-arms the 2940
//                   from its own registers after each completed block.
// ============================================================================
module dma_seq_2940 #(
    parameter int AW = 8,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] word_cnt,
    input  logic [2:0]    mode,
    input  logic          xfer_req,
`ifdef AUTOREINIT_EN
    input  logic          repeat_en,
`endif
    output logic          xfer_ack,
    input  logic          wco,
    output logic [CW-1:0] instr,
    output logic [AW-1:0] DataIn,
    output logic          aci,
    output logic          wci,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] xfer_cnt
);

    // State encoding
    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_WR_CR  = 3'd1;
    localparam logic [2:0] c_S_LD_ADR = 3'd2;
    localparam logic [2:0] c_S_LD_WC  = 3'd3;
    localparam logic [2:0] c_S_RUN    = 3'd4;
    localparam logic [2:0] c_S_DONE   = 3'd5;
`ifdef AUTOREINIT_EN
    localparam logic [2:0] c_S_REINIT = 3'd6;
`endif

    // 2940 instruction codes
    localparam logic [CW-1:0] c_I_WR_CR  = CW'(3'b000);
    localparam logic [CW-1:0] c_I_LD_ADR = CW'(3'b101);
    localparam logic [CW-1:0] c_I_LD_WC  = CW'(3'b110);
    localparam logic [CW-1:0] c_I_NOP    = CW'(3'b111);
`ifdef AUTOREINIT_EN
    localparam logic [CW-1:0] c_I_REINIT = CW'(3'b100);
`endif

    logic [2:0]    r_state;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_wc;
    logic [2:0]    r_mode;
    logic [CW-1:0] r_instr;
    logic [AW-1:0] r_data;
    logic          r_busy;
    logic          r_done;
    logic [AW-1:0] r_cnt;
    logic          w_ack;

    // A word is taken only while running and while the 2940 has not yet
    // reported end of count; the carry-ins follow the ack so the 2940
    // counters step exactly once per accepted word.
    assign w_ack    = (r_state == c_S_RUN) && xfer_req && wco;
    assign xfer_ack = w_ack;
    assign aci      = ~w_ack;
    assign wci      = ~w_ack;

    assign instr    = r_instr;
    assign DataIn   = r_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign xfer_cnt = r_cnt;

    // instr/DataIn/busy/done are loaded on the edge that enters a state so
    // they are valid for the whole cycle spent in that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_addr  <= '0;
            r_wc    <= '0;
            r_mode  <= '0;
            r_instr <= c_I_NOP;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_addr <= src_addr;
                        r_wc   <= word_cnt;
                        r_mode <= mode;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (word_cnt == '0) begin
                            // Empty block: nothing to program, finish at once.
                            r_state <= c_S_DONE;
                            r_done  <= 1'b1;
                            r_instr <= c_I_NOP;
                            r_data  <= '0;
                        end else begin
                            r_state <= c_S_WR_CR;
                            r_instr <= c_I_WR_CR;
                            r_data  <= {{(AW-3){1'b0}}, mode};
                        end
                    end
                end
                c_S_WR_CR: begin
                    r_state <= c_S_LD_ADR;
                    r_instr <= c_I_LD_ADR;
                    r_data  <= r_addr;
                end
                c_S_LD_ADR: begin
                    r_state <= c_S_LD_WC;
                    r_instr <= c_I_LD_WC;
                    r_data  <= r_wc;
                end
                c_S_LD_WC: begin
                    r_state <= c_S_RUN;
                    r_instr <= c_I_NOP;
                    r_data  <= '0;
                end
                c_S_RUN: begin
                    // Saturate rather than wrap so an over-long block still
                    // reads as "at least this many".
                    if (w_ack && (r_cnt != '1)) begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                    if (!wco) begin
                        r_state <= c_S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                c_S_DONE: begin
`ifdef AUTOREINIT_EN
                    if (repeat_en) begin
                        r_state <= c_S_REINIT;
                        r_instr <= c_I_REINIT;
                        r_data  <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= c_S_IDLE;
                        r_busy  <= 1'b0;
                    end
`else
                    r_state <= c_S_IDLE;
                    r_busy  <= 1'b0;
`endif
                end
`ifdef AUTOREINIT_EN
                c_S_REINIT: begin
                    r_state <= c_S_RUN;
                    r_instr <= c_I_NOP;
                end
`endif
                default: begin
                    r_state <= c_S_IDLE;
                    r_instr <= c_I_NOP;
                    r_data  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
